can_tx_arbiter: RTL and testbench
=================================

// Module: can_tx_arbiter
// PURPOSE
//  Shares one CAN transmitter among N_MBOX transmit mailboxes. Picks the pending mailbox with the
//  lowest identifier, which is the CAN bus priority; ties go to the lowest mailbox index.
//  Loads the frame fields into the transmitter and starts it, then tracks the outcome:
//  done, arbitration lost or error. Per-mailbox grant, ack and fail pulses go back to the mailboxes.
//  Sits between the mailbox register bank and the CAN TX bit engine; shares i_Clock with can_rx.
// PARAMETERS
//  N_MBOX     4    number of mailboxes (2..8)
//  ID_WIDTH   11   identifier width (11 standard, 29 extended)
//  DATA_WIDTH 64   payload width, 8 bytes
//  MAX_RETRY  15   error retransmissions allowed per mailbox (only with CAN_TX_ARB_RETRY_LIMIT_EN)
// PORTS
//  i_Clock      in   1                    system clock, same as CLKS_PER_BIT base clock
//  i_Reset      in   1                    synchronous, active-high reset
//  i_Req        in   N_MBOX               mailbox i has a frame pending (level)
//  i_Id         in   N_MBOX*ID_WIDTH      flattened IDs, mailbox i at [i*ID_WIDTH +: ID_WIDTH]
//  i_Dlc        in   N_MBOX*4             flattened DLCs
//  i_Data       in   N_MBOX*DATA_WIDTH    flattened payloads
//  i_Tx_Busy    in   1                    transmitter occupied (bus not idle)
//  i_Tx_Done    in   1                    1-cycle pulse: frame sent and ACKed
//  i_Arb_Lost   in   1                    1-cycle pulse: lost bus arbitration
//  i_Tx_Error   in   1                    1-cycle pulse: bit/stuff/ack error during frame
//  o_Tx_Start   out  1                    1-cycle pulse: transmitter latches o_Tx_* fields
//  o_Tx_Id      out  ID_WIDTH             selected ID, held stable from start until outcome
//  o_Tx_Dlc     out  4                    selected DLC
//  o_Tx_Data    out  DATA_WIDTH           selected payload
//  o_Grant      out  N_MBOX               one-hot owner, from LOAD until outcome
//  o_Ack        out  N_MBOX               1-cycle pulse to owner on i_Tx_Done
//  o_Fail       out  N_MBOX               1-cycle pulse: retry limit hit (tied 0 without macro)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; retry counters 0. Applies even mid-frame; no ack is issued.
//  FSM IDLE -> LOAD -> START -> WAIT.
//  - IDLE: if |i_Req && !i_Tx_Busy, register the winner index and go to LOAD.
//    Winner = min i_Id over requesting mailboxes; equal IDs resolve to the lowest index.
//  - LOAD: register o_Tx_Id, o_Tx_Dlc and o_Tx_Data from the winner; set o_Grant.
//    If i_Req[winner] has dropped, clear o_Grant and return to IDLE without starting.
//  - START: o_Tx_Start=1 for this cycle only; go to WAIT.
//  - WAIT: hold o_Tx_* and o_Grant; ignore changes on i_Req. Outcome precedence is
//    i_Tx_Done > i_Tx_Error > i_Arb_Lost when pulses coincide.
//    * Done: o_Ack[winner] pulse next cycle; clear the counter and o_Grant; go to IDLE.
//    * Arb lost: clear o_Grant; go to IDLE and re-arbitrate. Retry counter unchanged.
//    * Error: increment the winner's retry counter (saturating); clear o_Grant; go to IDLE.
//  Latency: o_Tx_Start is high 2 cycles after the IDLE cycle that sees a qualifying request.
//  o_Tx_* fields are valid in the START cycle. From an outcome pulse to the next o_Tx_Start
//  takes at least 3 cycles.
//  The ID compare is unsigned, full ID_WIDTH. Counters are $clog2(MAX_RETRY+1) bits wide.
// CONFIGURATION
//  `CAN_TX_ARB_RETRY_LIMIT_EN defined: an error is checked against the winner's counter
//    before incrementing. If the counter already equals MAX_RETRY:
//    o_Fail[winner] pulses instead of incrementing, and the counter clears.
//    The mailbox owner must drop i_Req; the arbiter retries if i_Req stays high.
//  Not defined: unlimited automatic retransmission (ISO 11898 default); o_Fail is constant 0;
//    no counter storage is synthesised.
// STRUCTURE
//  can_defs.vh (shared include): CAN_DLC_W=4, state encodings, default ID widths.
//  Sub-module can_id_min_select: combinational min-ID tree over the requesting mailboxes.
//    Outputs the winner index and a valid flag; reusable by a future RX filter.
//  Top-level: FSM, output registers, retry counter array.
// TESTING
//  1 Single request: mbox2 ID=0x123, DLC=8, data=0x0102..08 -> o_Tx_Start at +2 cycles with
//    those fields; i_Tx_Done -> o_Ack=4'b0100 for one cycle; o_Grant=0.
//  2 Priority: mbox0 ID=0x300, mbox3 ID=0x050 -> mbox3 served first, then mbox0.
//    Equal IDs 0x100 on mbox1 and mbox2 -> mbox1 first.
//  3 Arb lost: i_Arb_Lost in WAIT -> o_Grant clears; same mailbox restarted.
//    Meanwhile mbox0 raises ID=0x001 -> mbox0 wins the re-arbitration.
//  4 Coincident i_Tx_Done with i_Tx_Error -> treated as done; ack pulse; counter 0.
//  5 Retry limit (macro on, MAX_RETRY=2): 3 consecutive errors -> o_Fail pulse on the third,
//    no o_Ack. With the macro off, the 4th attempt starts normally.
//  6 i_Reset asserted in WAIT -> next cycle all outputs 0, state IDLE.
//    i_Tx_Busy high blocks any o_Tx_Start even with i_Req set.

Source files
------------

// File: rtl/can_tx_arbiter_pkg.sv
// Shared definitions for the CAN transmit arbiter slice: DLC width, default
// identifier/payload widths, mailbox limits and the arbiter state encoding.
// Imported by can_id_min_select and can_tx_arbiter.
package can_tx_arbiter_pkg;

    // A DLC is always four bits on the wire, even though only 0..8 are meaningful.
    localparam int CAN_DLC_W    = 4;

    // Standard-frame identifier width; extended frames use 29 bits.
    localparam int CAN_STD_ID_W = 11;

    // Classic CAN payload: up to 8 bytes.
    localparam int CAN_DATA_W   = 64;

    // Mailbox index range the arbiter is built for.
    localparam int CAN_MIN_MBOX = 2;
    localparam int CAN_MAX_MBOX = 8;

    // Arbiter sequencing: pick a winner, load its fields, start, then wait for the outcome.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_t;

    // Width of a counter that must hold 0..max_count inclusive (never narrower than 1 bit).
    function automatic int count_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/can_id_min_select.sv
// Combinational lowest-identifier selector over a set of requesting slots.
// Returns the index of the requesting slot with the smallest (unsigned) ID;
// equal IDs resolve to the lowest index. Kept generic so an RX acceptance
// filter can reuse it.
module can_id_min_select
    import can_tx_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int ID_WIDTH = CAN_STD_ID_W,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]          req,
    input  logic [N*ID_WIDTH-1:0] id_flat,
    output logic [IDX_W-1:0]      win_idx,
    output logic                  win_valid
);

    logic [ID_WIDTH-1:0] best_id;

    // Scan from slot 0 upward, replacing the candidate only on a strictly smaller ID
    // so the lowest index keeps ties.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        best_id   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (!win_valid || (id_flat[i*ID_WIDTH +: ID_WIDTH] < best_id))) begin
                win_valid = 1'b1;
                best_id   = id_flat[i*ID_WIDTH +: ID_WIDTH];
                win_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/can_tx_arbiter.sv
// Shares one CAN transmitter among N_MBOX transmit mailboxes. The pending
// mailbox with the lowest identifier wins (CAN bus priority, lowest index on
// ties); its fields are loaded into the transmitter, which is then started,
// and the outcome (done / error / arbitration lost) is reported back as
// per-mailbox grant, ack and fail signals.
// Optional feature: define CAN_TX_ARB_RETRY_LIMIT_EN to bound error
// retransmissions per mailbox to MAX_RETRY; otherwise retransmission is
// unlimited and o_Fail is constant 0.
module can_tx_arbiter
    import can_tx_arbiter_pkg::*;
#(
    parameter int N_MBOX     = 4,
    parameter int ID_WIDTH   = CAN_STD_ID_W,
    parameter int DATA_WIDTH = CAN_DATA_W,
    parameter int MAX_RETRY  = 15
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic [N_MBOX-1:0]            i_Req,
    input  logic [N_MBOX*ID_WIDTH-1:0]   i_Id,
    input  logic [N_MBOX*CAN_DLC_W-1:0]  i_Dlc,
    input  logic [N_MBOX*DATA_WIDTH-1:0] i_Data,
    input  logic                         i_Tx_Busy,
    input  logic                         i_Tx_Done,
    input  logic                         i_Arb_Lost,
    input  logic                         i_Tx_Error,
    output logic                         o_Tx_Start,
    output logic [ID_WIDTH-1:0]          o_Tx_Id,
    output logic [CAN_DLC_W-1:0]         o_Tx_Dlc,
    output logic [DATA_WIDTH-1:0]        o_Tx_Data,
    output logic [N_MBOX-1:0]            o_Grant,
    output logic [N_MBOX-1:0]            o_Ack,
    output logic [N_MBOX-1:0]            o_Fail
);

    localparam int IDX_W = $clog2(N_MBOX);

    // Reject parameter sets the index and counter arithmetic cannot represent.
    if (N_MBOX < CAN_MIN_MBOX || N_MBOX > CAN_MAX_MBOX || MAX_RETRY < 1) begin : g_bad_params
        $error("can_tx_arbiter: N_MBOX must be 2..8 and MAX_RETRY at least 1");
    end

    arb_state_t              state;
    logic [IDX_W-1:0]        winner;

    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_valid;
    logic [N_MBOX-1:0]       sel_onehot;
    logic [N_MBOX-1:0]       win_onehot;

    logic [ID_WIDTH-1:0]     win_id;
    logic [CAN_DLC_W-1:0]    win_dlc;
    logic [DATA_WIDTH-1:0]   win_data;

    logic                    out_done;
    logic                    out_error;
    logic                    out_lost;

    can_id_min_select #(
        .N        (N_MBOX),
        .ID_WIDTH (ID_WIDTH)
    ) u_min_select (
        .req       (i_Req),
        .id_flat   (i_Id),
        .win_idx   (sel_idx),
        .win_valid (sel_valid)
    );

    assign sel_onehot = N_MBOX'(1) << sel_idx;
    assign win_onehot = N_MBOX'(1) << winner;

    // Outcome decode: a done pulse beats an error, which beats a lost arbitration.
    assign out_done  = (state == ST_WAIT) && i_Tx_Done;
    assign out_error = (state == ST_WAIT) && !i_Tx_Done && i_Tx_Error;
    assign out_lost  = (state == ST_WAIT) && !i_Tx_Done && !i_Tx_Error && i_Arb_Lost;

    // Pick the registered winner's frame fields out of the flattened mailbox buses.
    always_comb begin
        win_id   = '0;
        win_dlc  = '0;
        win_data = '0;
        for (int i = 0; i < N_MBOX; i++) begin
            if (winner == IDX_W'(i)) begin
                win_id   = i_Id[i*ID_WIDTH +: ID_WIDTH];
                win_dlc  = i_Dlc[i*CAN_DLC_W +: CAN_DLC_W];
                win_data = i_Data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Arbiter sequencing with registered transmitter fields, grant, start and ack.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state      <= ST_IDLE;
            winner     <= '0;
            o_Tx_Start <= 1'b0;
            o_Tx_Id    <= '0;
            o_Tx_Dlc   <= '0;
            o_Tx_Data  <= '0;
            o_Grant    <= '0;
            o_Ack      <= '0;
        end else begin
            o_Tx_Start <= 1'b0;
            o_Ack      <= '0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid && !i_Tx_Busy) begin
                        winner  <= sel_idx;
                        o_Grant <= sel_onehot;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (i_Req[winner]) begin
                        o_Tx_Id    <= win_id;
                        o_Tx_Dlc   <= win_dlc;
                        o_Tx_Data  <= win_data;
                        o_Tx_Start <= 1'b1;
                        state      <= ST_START;
                    end else begin
                        o_Grant <= '0;
                        state   <= ST_IDLE;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (out_done) begin
                        o_Ack   <= win_onehot;
                        o_Grant <= '0;
                        state   <= ST_IDLE;
                    end else if (out_error || out_lost) begin
                        o_Grant <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
    localparam int CNT_W = count_width(MAX_RETRY);

    logic [CNT_W-1:0] retry_cnt [N_MBOX];
    logic             at_limit;

    assign at_limit = (retry_cnt[winner] == CNT_W'(MAX_RETRY));

    // Per-mailbox error counters; hitting the limit reports a failure and rearms the
    // counter, so the count never passes MAX_RETRY and needs no separate saturation.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int i = 0; i < N_MBOX; i++) begin
                retry_cnt[i] <= '0;
            end
            o_Fail <= '0;
        end else begin
            o_Fail <= '0;
            if (out_done) begin
                retry_cnt[winner] <= '0;
            end else if (out_error) begin
                if (at_limit) begin
                    o_Fail            <= win_onehot;
                    retry_cnt[winner] <= '0;
                end else begin
                    retry_cnt[winner] <= retry_cnt[winner] + 1'b1;
                end
            end
        end
    end
`else
    assign o_Fail = '0;
`endif

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed testbench for can_tx_arbiter with a scoreboard: stimulus pushes the
// expected start/ack/fail events, a monitor pops and compares them whenever
// the DUT presents one. Works with or without CAN_TX_ARB_RETRY_LIMIT_EN.
module tb_can_tx_arbiter;

    localparam int N      = 4;
    localparam int ID_W   = 11;
    localparam int DLC_W  = 4;
    localparam int DATA_W = 64;
    localparam int RETRY  = 2;

`ifdef CAN_TX_ARB_RETRY_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    localparam logic [7:0] EV_START = 8'd0;
    localparam logic [7:0] EV_ACK   = 8'd1;
    localparam logic [7:0] EV_FAIL  = 8'd2;

    typedef struct {
        logic [7:0]        kind;
        logic [ID_W-1:0]   id;
        logic [DLC_W-1:0]  dlc;
        logic [DATA_W-1:0] data;
        logic [N-1:0]      mask;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req;
    logic [N*ID_W-1:0]   id_bus;
    logic [N*DLC_W-1:0]  dlc_bus;
    logic [N*DATA_W-1:0] data_bus;
    logic                tx_busy;
    logic                tx_done;
    logic                arb_lost;
    logic                tx_error;
    logic                tx_start;
    logic [ID_W-1:0]     tx_id;
    logic [DLC_W-1:0]    tx_dlc;
    logic [DATA_W-1:0]   tx_data;
    logic [N-1:0]        grant;
    logic [N-1:0]        ack;
    logic [N-1:0]        fail;

    int   tests  = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    can_tx_arbiter #(
        .N_MBOX     (N),
        .ID_WIDTH   (ID_W),
        .DATA_WIDTH (DATA_W),
        .MAX_RETRY  (RETRY)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Req      (req),
        .i_Id       (id_bus),
        .i_Dlc      (dlc_bus),
        .i_Data     (data_bus),
        .i_Tx_Busy  (tx_busy),
        .i_Tx_Done  (tx_done),
        .i_Arb_Lost (arb_lost),
        .i_Tx_Error (tx_error),
        .o_Tx_Start (tx_start),
        .o_Tx_Id    (tx_id),
        .o_Tx_Dlc   (tx_dlc),
        .o_Tx_Data  (tx_data),
        .o_Grant    (grant),
        .o_Ack      (ack),
        .o_Fail     (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] packEvent(input logic [7:0] kind, input logic [ID_W-1:0] id,
                                               input logic [DLC_W-1:0] dlc, input logic [DATA_W-1:0] data,
                                               input logic [N-1:0] mask);
        return {37'd0, kind, id, dlc, data, mask};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [N-1:0] mask);
        tests++;
        errors++;
        $display("[TB] FAIL %s: got unexpected event mask=%b, expected none", name, mask);
    endtask

    // Scoreboard monitor: every DUT event must match the oldest pending expectation.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                reportUnexpected("start", grant);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("start", packEvent(EV_START, tx_id, tx_dlc, tx_data, grant),
                            packEvent(mon_e.kind, mon_e.id, mon_e.dlc, mon_e.data, mon_e.mask));
            end
        end
        if (ack !== '0 && !$isunknown(ack)) begin
            if (exp_q.size() == 0) begin
                reportUnexpected("ack", ack);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("ack", packEvent(EV_ACK, '0, '0, '0, ack),
                            packEvent(mon_e.kind, '0, '0, '0, mon_e.mask));
            end
        end
        if (fail !== '0 && !$isunknown(fail)) begin
            if (exp_q.size() == 0) begin
                reportUnexpected("fail", fail);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("fail", packEvent(EV_FAIL, '0, '0, '0, fail),
                            packEvent(mon_e.kind, '0, '0, '0, mon_e.mask));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic [ID_W-1:0] id, input logic [DLC_W-1:0] dlc,
                                 input logic [DATA_W-1:0] data);
        id_bus[m*ID_W +: ID_W]       = id;
        dlc_bus[m*DLC_W +: DLC_W]    = dlc;
        data_bus[m*DATA_W +: DATA_W] = data;
        req[m]                       = 1'b1;
    endtask

    task automatic pushEvent(input logic [7:0] kind, input int m, input logic [ID_W-1:0] id,
                             input logic [DLC_W-1:0] dlc, input logic [DATA_W-1:0] data);
        exp_t e;
        e.kind = kind;
        e.id   = id;
        e.dlc  = dlc;
        e.data = data;
        e.mask = N'(1) << m;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for o_Tx_Start; returns the number of cycles it took.
    task automatic waitStart(output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            n++;
            if (tx_start === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            errors++;
            $display("[TB] FAIL start_timeout: got no o_Tx_Start in %0d cycles, expected one", n);
        end
    endtask

    // Called in the START cycle: steps into WAIT, drives one outcome pulse, registers
    // the expected ack/fail and optionally lets the owner drop its request.
    task automatic pulseOutcome(input int m, input bit done, input bit err, input bit lost,
                                input bit exp_fail, input bit drop);
        tick();
        tx_done  = done;
        tx_error = err;
        arb_lost = lost;
        if (done)     pushEvent(EV_ACK, m, '0, '0, '0);
        if (exp_fail) pushEvent(EV_FAIL, m, '0, '0, '0);
        tick();
        tx_done  = 1'b0;
        tx_error = 1'b0;
        arb_lost = 1'b0;
        if (drop) req[m] = 1'b0;
    endtask

    task automatic serveFrame(input int m, input logic [ID_W-1:0] id, input logic [DLC_W-1:0] dlc,
                              input logic [DATA_W-1:0] data);
        int n;
        pushEvent(EV_START, m, id, dlc, data);
        waitStart(n);
        pulseOutcome(m, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, {37'd0, 7'd0, tx_start, tx_id, tx_dlc, tx_data, grant, ack, fail},
                    128'd0);
    endtask

    initial begin
        int n;
        bit started;

        rst      = 1'b1;
        req      = '0;
        id_bus   = '0;
        dlc_bus  = '0;
        data_bus = '0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        arb_lost = 1'b0;
        tx_error = 1'b0;
        repeat (3) tick();
        checkAllZero("reset_state");
        rst = 1'b0;
        tick();

        $display("[TB] test 1: single request");
        applyStimulus(2, 11'h123, 4'd8, 64'h0102030405060708);
        pushEvent(EV_START, 2, 11'h123, 4'd8, 64'h0102030405060708);
        waitStart(n);
        checkOutput("start_latency", 128'(n), 128'd2);
        checkOutput("grant_in_start", 128'(grant), 128'(4'b0100));
        tick();
        checkOutput("grant_in_wait", 128'(grant), 128'(4'b0100));
        tx_done = 1'b1;
        pushEvent(EV_ACK, 2, '0, '0, '0);
        tick();
        tx_done = 1'b0;
        req[2]  = 1'b0;
        checkOutput("ack_pulse", 128'(ack), 128'(4'b0100));
        checkOutput("grant_after_done", 128'(grant), 128'd0);
        tick();
        checkOutput("ack_one_cycle", 128'(ack), 128'd0);

        $display("[TB] test 2: priority and tie-break");
        applyStimulus(0, 11'h300, 4'd1, 64'h00000000000000A0);
        applyStimulus(3, 11'h050, 4'd2, 64'h000000000000B3B3);
        serveFrame(3, 11'h050, 4'd2, 64'h000000000000B3B3);
        pushEvent(EV_START, 0, 11'h300, 4'd1, 64'h00000000000000A0);
        waitStart(n);
        checkOutput("outcome_to_start", 128'(n), 128'd2);
        pulseOutcome(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 11'h100, 4'd3, 64'h0000000000111111);
        applyStimulus(2, 11'h100, 4'd4, 64'h0000000022222222);
        serveFrame(1, 11'h100, 4'd3, 64'h0000000000111111);
        serveFrame(2, 11'h100, 4'd4, 64'h0000000022222222);

        $display("[TB] test 3: arbitration lost");
        applyStimulus(2, 11'h200, 4'd5, 64'h0000003333333333);
        pushEvent(EV_START, 2, 11'h200, 4'd5, 64'h0000003333333333);
        waitStart(n);
        pulseOutcome(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("grant_after_lost", 128'(grant), 128'd0);
        pushEvent(EV_START, 2, 11'h200, 4'd5, 64'h0000003333333333);
        waitStart(n);
        applyStimulus(0, 11'h001, 4'd6, 64'h0000444444444444);
        pulseOutcome(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        serveFrame(0, 11'h001, 4'd6, 64'h0000444444444444);
        serveFrame(2, 11'h200, 4'd5, 64'h0000003333333333);

        $display("[TB] test 4: done and error together");
        applyStimulus(1, 11'h0AA, 4'd2, 64'h000000000000CAFE);
        pushEvent(EV_START, 1, 11'h0AA, 4'd2, 64'h000000000000CAFE);
        waitStart(n);
        pulseOutcome(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pushEvent(EV_START, 1, 11'h0AA, 4'd2, 64'h000000000000CAFE);
        waitStart(n);
        pulseOutcome(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("[TB] test 5: repeated errors");
        applyStimulus(1, 11'h0AA, 4'd2, 64'h000000000000CAFE);
        for (int k = 0; k < 3; k++) begin
            pushEvent(EV_START, 1, 11'h0AA, 4'd2, 64'h000000000000CAFE);
            waitStart(n);
            pulseOutcome(1, 1'b0, 1'b1, 1'b0, LIMIT_ON && (k == 2), 1'b0);
        end
        serveFrame(1, 11'h0AA, 4'd2, 64'h000000000000CAFE);

        $display("[TB] test 6: reset mid-frame, withdrawn request, busy");
        applyStimulus(3, 11'h010, 4'd7, 64'h5555555555555555);
        pushEvent(EV_START, 3, 11'h010, 4'd7, 64'h5555555555555555);
        waitStart(n);
        tick();
        rst = 1'b1;
        tick();
        checkAllZero("reset_in_wait");
        rst    = 1'b0;
        req[3] = 1'b0;
        tick();
        applyStimulus(2, 11'h011, 4'd1, 64'h0000000000000077);
        tick();
        checkOutput("grant_in_load", 128'(grant), 128'(4'b0100));
        req[2] = 1'b0;
        tick();
        checkOutput("grant_after_withdraw", 128'(grant), 128'd0);
        tx_busy = 1'b1;
        applyStimulus(0, 11'h055, 4'd8, 64'h6666666666666666);
        started = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (tx_start !== 1'b0) started = 1'b1;
        end
        checkOutput("busy_blocks_start", 128'(started), 128'd0);
        pushEvent(EV_START, 0, 11'h055, 4'd8, 64'h6666666666666666);
        tx_busy = 1'b0;
        waitStart(n);
        checkOutput("start_after_busy", 128'(n), 128'd2);
        pulseOutcome(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (5) tick();
        checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // Global time bound so a stuck DUT still ends the run.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got no completion by time limit, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
